// File: rtl/draw_pass_scheduler.sv
// Frame-level sequencer for the shared VGA write port: runs the enabled draw
// passes in index order through a start/done level handshake, muxes the active
// pass onto the VGA adapter and flags timeouts, overruns and write conflicts.
module draw_pass_scheduler #(
    parameter int unsigned NUM_PASSES = 4,
    parameter int unsigned X_W        = 9,
    parameter int unsigned Y_W        = 8,
    parameter int unsigned COLOUR_W   = 3,
    parameter int unsigned TIMEOUT    = 131071
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           frame_tick_i,
    input  logic [NUM_PASSES-1:0]          pass_enable_i,
    input  logic                           clear_req_i,
    input  logic [NUM_PASSES-1:0]          pass_done_i,
    input  logic [NUM_PASSES*X_W-1:0]      pass_x_i,
    input  logic [NUM_PASSES*Y_W-1:0]      pass_y_i,
    input  logic [NUM_PASSES*COLOUR_W-1:0] pass_colour_i,
    input  logic [NUM_PASSES-1:0]          pass_we_i,
    output logic [NUM_PASSES-1:0]          pass_start_o,
    output logic                           clear_screen_o,
    output logic [X_W-1:0]                 vga_x_o,
    output logic [Y_W-1:0]                 vga_y_o,
    output logic [COLOUR_W-1:0]            vga_colour_o,
    output logic                           vga_we_o,
    output logic                           busy_o,
    output logic                           frame_done_o,
    output logic                           err_timeout_o,
    output logic                           err_overrun_o,
    output logic                           err_conflict_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_PASSES + 1);
    localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TLAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_WAIT_DONE,
        S_RELEASE,
        S_FRAME_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
    logic [NUM_PASSES-1:0]   mask_q, mask_d;
    logic                    pending_q, pending_d;
    logic                    clear_latch_q, clear_latch_d;
    logic                    clear_screen_q, clear_screen_d;
    logic [NUM_PASSES-1:0]   pass_start_q, pass_start_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;
    logic                    err_timeout_q, err_timeout_d;
    logic                    err_overrun_q, err_overrun_d;
    logic                    err_conflict_q, err_conflict_d;

    logic                    mask_sel_c;
    logic                    done_sel_c;
    logic                    conflict_c;
    logic                    drive_c;

    // Active-pass selection, write mux and conflict detection
    always_comb begin
        vga_x_o      = '0;
        vga_y_o      = '0;
        vga_colour_o = '0;
        vga_we_o     = 1'b0;
        mask_sel_c   = 1'b0;
        done_sel_c   = 1'b0;
        conflict_c   = 1'b0;
        drive_c      = (state_q == S_START) || (state_q == S_WAIT_DONE) ||
                       (state_q == S_RELEASE);
        for (int i = 0; i < NUM_PASSES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                mask_sel_c = mask_q[i];
                done_sel_c = pass_done_i[i];
                if (drive_c) begin
                    vga_x_o      = pass_x_i[i*X_W +: X_W];
                    vga_y_o      = pass_y_i[i*Y_W +: Y_W];
                    vga_colour_o = pass_colour_i[i*COLOUR_W +: COLOUR_W];
                    // writes outside WAIT_DONE are flagged and dropped
                    vga_we_o     = pass_we_i[i] && (state_q == S_WAIT_DONE);
                end
                if (pass_we_i[i] && (state_q != S_WAIT_DONE)) begin
                    conflict_c = 1'b1;
                end
            end else if (pass_we_i[i]) begin
                conflict_c = 1'b1;
            end
        end
    end

    // Next-state, frame queueing, clear latch and registered-output decode
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        tcnt_d         = tcnt_q;
        mask_d         = mask_q;
        pending_d      = pending_q;
        clear_latch_d  = clear_latch_q | clear_req_i;
        clear_screen_d = clear_screen_q;
        err_timeout_d  = err_timeout_q;
        err_overrun_d  = err_overrun_q;
        err_conflict_d = err_conflict_q | conflict_c;

        // only one frame can be queued behind the running one
        if (frame_tick_i && (state_q != S_IDLE)) begin
            if (pending_q) begin
                err_overrun_d = 1'b1;
            end
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_tick_i || pending_q) begin
                    mask_d         = pass_enable_i;
                    idx_d          = '0;
                    pending_d      = 1'b0;
                    clear_screen_d = clear_latch_q | clear_req_i;
                    clear_latch_d  = 1'b0;
                    state_d        = S_SELECT;
                end
            end
            S_SELECT: begin
                if (idx_q == IDX_W'(NUM_PASSES)) begin
                    state_d = S_FRAME_DONE;
                end else if (mask_sel_c) begin
                    state_d = S_START;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                tcnt_d = tcnt_q + TCNT_W'(1);
                if (done_sel_c) begin
                    state_d = S_RELEASE;
                end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_W'(TLAST))) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // no timeout here: a controller stuck in done holds the frame
                if (!done_sel_c) begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_SELECT;
                end
            end
            S_FRAME_DONE: begin
                clear_screen_d = 1'b0;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_FRAME_DONE);
        pass_start_d = '0;
        for (int i = 0; i < NUM_PASSES; i++) begin
            if (((state_d == S_START) || (state_d == S_WAIT_DONE)) &&
                (idx_d == IDX_W'(i))) begin
                pass_start_d[i] = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            tcnt_q         <= '0;
            mask_q         <= '0;
            pending_q      <= 1'b0;
            clear_latch_q  <= 1'b0;
            clear_screen_q <= 1'b0;
            pass_start_q   <= '0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
            err_conflict_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            tcnt_q         <= tcnt_d;
            mask_q         <= mask_d;
            pending_q      <= pending_d;
            clear_latch_q  <= clear_latch_d;
            clear_screen_q <= clear_screen_d;
            pass_start_q   <= pass_start_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            err_timeout_q  <= err_timeout_d;
            err_overrun_q  <= err_overrun_d;
            err_conflict_q <= err_conflict_d;
        end
    end

    assign pass_start_o   = pass_start_q;
    assign clear_screen_o = clear_screen_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = frame_done_q;
    assign err_timeout_o  = err_timeout_q;
    assign err_overrun_o  = err_overrun_q;
    assign err_conflict_o = err_conflict_q;

endmodule

// File: tb/tb_draw_pass_scheduler.sv
// Scoreboard bench for draw_pass_scheduler: reactive controller stubs, an
// expected-event queue (pass starts, frame completions) and an expected-write
// queue, each drained by a monitor that watches the DUT outputs.
module tb_draw_pass_scheduler;

    localparam int unsigned NP = 4;
    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam int unsigned CW = 3;
    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick = 1'b0;
    logic              clear_req = 1'b0;
    logic [NP-1:0]     en = '0;
    logic [NP-1:0]     pdone;
    logic [NP*XW-1:0]  px = '0;
    logic [NP*YW-1:0]  py = '0;
    logic [NP*CW-1:0]  pc = '0;
    logic [NP-1:0]     pwe;
    logic [NP-1:0]     pstart;
    logic              clear_screen, vga_we, busy, frame_done;
    logic [XW-1:0]     vga_x;
    logic [YW-1:0]     vga_y;
    logic [CW-1:0]     vga_c;
    logic              err_to, err_ov, err_cf;

    draw_pass_scheduler #(
        .NUM_PASSES(NP), .X_W(XW), .Y_W(YW), .COLOUR_W(CW), .TIMEOUT(TO)
    ) dut (
        .clock_i(clk), .reset_i(rst), .frame_tick_i(tick),
        .pass_enable_i(en), .clear_req_i(clear_req), .pass_done_i(pdone),
        .pass_x_i(px), .pass_y_i(py), .pass_colour_i(pc), .pass_we_i(pwe),
        .pass_start_o(pstart), .clear_screen_o(clear_screen),
        .vga_x_o(vga_x), .vga_y_o(vga_y), .vga_colour_o(vga_c), .vga_we_o(vga_we),
        .busy_o(busy), .frame_done_o(frame_done),
        .err_timeout_o(err_to), .err_overrun_o(err_ov), .err_conflict_o(err_cf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_frame;
        logic [3:0] idx;
        logic       clr;
    } ev_t;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } wr_t;

    ev_t exp_q[$];
    wr_t wr_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    bit clr_model = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller stubs: assert done dly cycles after start, write while working
    logic [NP-1:0] done_s = '0;
    logic [NP-1:0] hang   = '0;
    logic [NP-1:0] rogue  = '0;
    int cnt [NP];
    int dly [NP];
    int rel [NP];
    int force_d = 0;

    assign pdone = done_s;
    for (genvar g = 0; g < NP; g++) begin : g_we
        assign pwe[g] = (pstart[g] & ~done_s[g] & (cnt[g] >= 2)) | rogue[g];
    end

    always @(negedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (pstart[i]) begin
                if (!done_s[i]) begin
                    cnt[i] = cnt[i] + 1;
                    if (!hang[i] && cnt[i] >= dly[i]) done_s[i] = 1'b1;
                end
            end else begin
                cnt[i] = 0;
                if (done_s[i]) begin
                    if (rel[i] == 0) done_s[i] = 1'b0;
                    else rel[i] = rel[i] - 1;
                end else begin
                    dly[i] = (force_d != 0) ? force_d : int'($urandom_range(2, 10));
                    rel[i] = int'($urandom_range(0, 3));
                end
            end
            px[i*XW +: XW] = XW'($urandom);
            py[i*YW +: YW] = YW'($urandom);
            pc[i*CW +: CW] = CW'($urandom);
        end
        for (int i = 0; i < NP; i++) begin
            if (pstart[i] && !done_s[i] && cnt[i] >= 2)
                wr_q.push_back({px[i*XW +: XW], py[i*YW +: YW], pc[i*CW +: CW]});
        end
    end

    // Monitor: match start rises and frame_done to expected events, writes to wr_q
    logic [NP-1:0] prev_start = '0;
    int w1 = 0;
    always @(negedge clk) begin
        logic [NP-1:0] rises;
        ev_t e;
        wr_t w;
        #1;
        rises = pstart & ~prev_start;
        if (rises != '0) chk("start_onehot", 32'($countones(pstart)), 32'd1);
        for (int i = 0; i < NP; i++) begin
            if (rises[i]) begin
                if (exp_q.size() == 0) chk("start_unexpected", 32'(i), 32'hFF);
                else begin
                    e = exp_q.pop_front();
                    chk("ev_is_start", 32'(e.is_frame), 32'd0);
                    chk("start_idx", 32'(i), 32'(e.idx));
                    chk("start_clear_screen", 32'(clear_screen), 32'(e.clr));
                end
            end
        end
        if (frame_done) begin
            if (exp_q.size() == 0) chk("frame_done_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("ev_is_frame", 32'(e.is_frame), 32'd1);
                chk("frame_clear_screen", 32'(clear_screen), 32'(e.clr));
            end
        end
        if (pstart[1]) w1++;
        else if (prev_start[1]) begin
            if (hang[1]) chk("timeout_start_width", 32'((w1 == TO) || (w1 == TO + 1)), 32'd1);
            w1 = 0;
        end
        prev_start = pstart;
        if (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            chk("vga_we", 32'(vga_we), 32'd1);
            chk("vga_data", 32'({vga_x, vga_y, vga_c}), 32'(w));
        end else if (vga_we) begin
            chk("vga_we_spurious", 32'(vga_we), 32'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_req = 1'b1; clr_model = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic push_frame(input logic [NP-1:0] m, input bit clr);
        for (int i = 0; i < NP; i++)
            if (m[i]) exp_q.push_back('{is_frame: 1'b0, idx: 4'(i), clr: clr});
        exp_q.push_back('{is_frame: 1'b1, idx: 4'd0, clr: clr});
    endtask

    // Issue a frame while idle; clear_req may coincide with the tick
    task automatic start_frame(input logic [NP-1:0] m, input bit clr_with_tick);
        bit fclr;
        @(posedge clk); #1;
        en = m; tick = 1'b1; clear_req = clr_with_tick;
        fclr = clr_model | clr_with_tick;
        clr_model = 1'b0;
        push_frame(m, fclr);
        @(posedge clk); #1 tick = 1'b0; clear_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < budget) begin
            @(posedge clk); #1; n++;
            if (!busy && exp_q.size() == 0 && pdone == '0) quiet++;
            else quiet = 0;
        end
        chk("idle_reached", 32'(quiet >= 4), 32'd1);
    endtask

    task automatic wait_start(input int i, input int budget);
        int n = 0;
        while (!pstart[i] && n < budget) begin @(posedge clk); #1; n++; end
        chk("start_seen", 32'(pstart[i]), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        cyc(3);
        chk("rst_pass_start", 32'(pstart), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_clear_screen", 32'(clear_screen), 32'd0);
        chk("rst_vga_we", 32'(vga_we), 32'd0);
        chk("rst_errors", 32'({err_to, err_ov, err_cf}), 32'd0);
        rst = 1'b0;
        cyc(2);

        // empty mask: frame_done NUM_PASSES+2 cycles after the tick cycle
        start_frame('0, 1'b0);
        k = 0;
        while (!frame_done && k < 50) begin @(posedge clk); #1; k++; end
        chk("empty_mask_latency", 32'(k + 1), 32'(NP + 2));
        wait_idle(100);

        // all passes, then sparse mask
        start_frame(4'b1111, 1'b0);
        wait_idle(500);
        start_frame(4'b0101, 1'b0);
        wait_idle(500);

        // clear_req before the tick applies to that frame only
        pulse_clear();
        start_frame(4'b0011, 1'b0);
        wait_idle(500);
        start_frame(4'b0011, 1'b0);
        wait_idle(500);

        // randomized frames, clear requests before, with and during frames
        repeat (25) begin
            if ($urandom_range(0, 2) == 0) pulse_clear();
            start_frame(NP'($urandom), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cyc(int'($urandom_range(1, 5)));
                pulse_clear();
            end
            wait_idle(500);
        end
        chk("no_errors_after_random", 32'({err_to, err_ov, err_cf}), 32'd0);

        // pass 1 never completes: aborted on timeout, pass 2 still runs
        hang[1] = 1'b1;
        start_frame(4'b0111, 1'b0);
        wait_idle(500);
        hang[1] = 1'b0;
        chk("err_timeout_set", 32'(err_to), 32'd1);

        // ticks while busy: one queued frame, overrun on the next
        force_d = 40;
        cyc(2);
        start_frame(4'b0001, 1'b0);
        wait_start(0, 50);
        pulse_tick();
        push_frame(4'b0001, 1'b0);
        cyc(2);
        chk("err_overrun_after_second", 32'(err_ov), 32'd0);
        pulse_tick();
        cyc(2);
        chk("err_overrun_after_third", 32'(err_ov), 32'd1);
        wait_idle(1000);

        // rogue write from pass 3 while pass 1 is active
        force_d = 20;
        cyc(2);
        chk("err_conflict_clear", 32'(err_cf), 32'd0);
        start_frame(4'b0010, 1'b0);
        wait_start(1, 50);
        cyc(4);
        @(negedge clk) rogue[3] = 1'b1;
        repeat (2) @(negedge clk);
        rogue[3] = 1'b0;
        wait_idle(500);
        chk("err_conflict_set", 32'(err_cf), 32'd1);
        force_d = 0;
        cyc(2);

        // reset mid-frame
        start_frame(4'b1111, 1'b0);
        wait_start(0, 50);
        cyc(2);
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        clr_model = 1'b0;
        @(posedge clk); #1;
        chk("midrst_pass_start", 32'(pstart), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_errors", 32'({err_to, err_ov, err_cf}), 32'd0);
        rst = 1'b0;
        wait_idle(100);
        start_frame(4'b1010, 1'b1);
        wait_idle(500);
        chk("final_write_queue_empty", 32'(wr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
